// File: rtl/systolic_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg
//
// Shared definitions for the systolic array operand path.
//   clogb2         : ceiling log2, never less than 1 so it can size a port
//   mat_sel_e      : which operand matrix a host stream targets (A or B)
//   store_state_e  : load FSM states of the operand store
// ---------------------------------------------------------------------------
package systolic_pkg;

  // Ceiling log2 with a floor of 1: a one-entry structure still needs a
  // one-bit index so that every port keeps a legal width.
  function automatic int clogb2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

  typedef enum logic {
    MAT_A = 1'b0,
    MAT_B = 1'b1
  } mat_sel_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } store_state_e;

endpackage

// File: rtl/operand_bank.sv
// ---------------------------------------------------------------------------
// operand_bank
//
// Word-organised operand storage: DEPTH words of LANES elements each.
// One element (one lane of one word) can be written per cycle; reads are
// combinational and return zero for addresses beyond the populated depth.
//
// Ports
//   clk       : clock, all state on rising edge
//   rst       : asynchronous active-high reset, clears every word
//   we_i      : per-lane write enable (one-hot or zero)
//   waddr_i   : word address of the write
//   wdata_i   : element value written into the enabled lane(s)
//   raddr_i   : combinational read address
//   rdata_o   : packed word, lane l in bits [(l+1)*DATA_WIDTH-1 -: DATA_WIDTH]
// ---------------------------------------------------------------------------
module operand_bank
  import systolic_pkg::*;
#(
  parameter int LANES      = 3,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 6,
  parameter int AW         = clogb2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LANES-1:0]            we_i,
  input  logic [AW-1:0]               waddr_i,
  input  logic [DATA_WIDTH-1:0]       wdata_i,
  input  logic [AW-1:0]               raddr_i,
  output logic [LANES*DATA_WIDTH-1:0] rdata_o
);

  logic [LANES*DATA_WIDTH-1:0] mem_q [DEPTH];

  // Storage array. Only the enabled lane of the addressed word changes, so
  // an element written by one beat never disturbs its neighbours in the word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_q[w] <= '0;
      end
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (we_i[l] && (int'(waddr_i) < DEPTH)) begin
          mem_q[waddr_i][l*DATA_WIDTH +: DATA_WIDTH] <= wdata_i;
        end
      end
    end
  end

  // Zero-latency read; addresses past the last real word read as zero.
  always_comb begin
    rdata_o = '0;
    if (int'(raddr_i) < DEPTH) begin
      rdata_o = mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/matrix_operand_store.sv
// ---------------------------------------------------------------------------
// matrix_operand_store
//
// Operand memory on the read side of the systolic array. A host streams
// N x N matrices element by element in row-major order; A matrices are
// stored as column words and B matrices as row words, one word per address
// (word address = slot*N + k). Per-slot full flags gate loading and tell the
// array controller when both operands of a slot are present.
//
// Ports
//   clk, rst                 : clock / asynchronous active-high reset
//   wr_valid, wr_ready       : host element handshake
//   wr_data                  : element value
//   wr_sel, wr_slot          : target matrix / slot, sampled on the first beat
//   wr_last                  : host marks the final element of the matrix
//   rel_valid, rel_slot      : controller releases a consumed slot
//   addr_matrix_A/B          : array read addresses
//   MATRIX_A_COL/MATRIX_B_ROW: packed combinational read words
//   slot_ready               : per slot, A and B both loaded
//   err, err_clr             : sticky framing error and its clear
// ---------------------------------------------------------------------------
module matrix_operand_store
  import systolic_pkg::*;
#(
  parameter  int ARRAY_SIZE   = 3,
  parameter  int DATA_WIDTH   = 8,
  parameter  int MAX_MATRICES = 2,
  parameter  int AW           = clogb2(ARRAY_SIZE * MAX_MATRICES),
  localparam int SW           = clogb2(MAX_MATRICES)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic                             wr_sel,
  input  logic [SW-1:0]                    wr_slot,
  input  logic                             wr_last,
  input  logic                             rel_valid,
  input  logic [SW-1:0]                    rel_slot,
  input  logic [AW-1:0]                    addr_matrix_A,
  input  logic [AW-1:0]                    addr_matrix_B,
  output logic [DATA_WIDTH*ARRAY_SIZE-1:0] MATRIX_A_COL,
  output logic [DATA_WIDTH*ARRAY_SIZE-1:0] MATRIX_B_ROW,
  output logic [MAX_MATRICES-1:0]          slot_ready,
  output logic                             err,
  input  logic                             err_clr
);

  localparam int N     = ARRAY_SIZE;
  localparam int NN    = N * N;
  localparam int DEPTH = N * MAX_MATRICES;
  localparam int CW    = clogb2(NN);
  localparam int IW    = clogb2(N);

  store_state_e          state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [IW-1:0]         row_q, row_d;
  logic [IW-1:0]         col_q, col_d;
  mat_sel_e              sel_q, sel_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic [MAX_MATRICES-1:0] aFull_q, aFull_d;
  logic [MAX_MATRICES-1:0] bFull_q, bFull_d;
  logic                  err_q, err_d;
  logic                  rstDone_q;

  mat_sel_e              beatSel;
  logic [SW-1:0]         beatSlot;
  logic [IW-1:0]         beatRow;
  logic [IW-1:0]         beatCol;
  logic [CW-1:0]         beatIdx;
  logic                  slotInRange;
  logic                  relInRange;
  logic                  targetFull;
  logic                  accept;
  logic                  isFinalIdx;
  logic                  goodLast;
  logic                  frameErr;
  logic [AW-1:0]         slotBase;
  logic [AW-1:0]         waddrA;
  logic [AW-1:0]         waddrB;
  logic [N-1:0]          weA;
  logic [N-1:0]          weB;

  // In IDLE the beat context comes straight from the host (first beat);
  // afterwards it comes from what that first beat latched.
  always_comb begin
    beatSel  = sel_q;
    beatSlot = slot_q;
    beatRow  = row_q;
    beatCol  = col_q;
    beatIdx  = count_q;
    if (state_q == IDLE) begin
      beatSel  = mat_sel_e'(wr_sel);
      beatSlot = wr_slot;
      beatRow  = '0;
      beatCol  = '0;
      beatIdx  = '0;
    end
  end

  // Target-slot screening for the first beat. An out-of-range slot is
  // treated as permanently full so the host can never start a load there.
  always_comb begin
    slotInRange = int'(wr_slot) < MAX_MATRICES;
    relInRange  = int'(rel_slot) < MAX_MATRICES;
    targetFull  = 1'b1;
    if (slotInRange) begin
      targetFull = wr_sel ? bFull_q[wr_slot] : aFull_q[wr_slot];
    end
  end

  // Framing decode: a beat is well-framed only when wr_last coincides with
  // the N*N-th element. Any disagreement aborts the load.
  assign accept     = wr_valid & wr_ready;
  assign isFinalIdx = (beatIdx == CW'(NN - 1));
  assign goodLast   = accept & wr_last & isFinalIdx;
  assign frameErr   = accept & (wr_last != isFinalIdx);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state. A single accepted beat covers both the first beat in
  // IDLE and the streaming beats in LOAD, which also handles N=1 where the
  // first beat is already the final one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          if (goodLast) begin
            state_d = COMMIT;
          end else if (frameErr) begin
            state_d = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: host ready and the per-lane write strobes. rstDone_q keeps
  // wr_ready low until the first clock edge after reset is released.
  always_comb begin
    wr_ready = 1'b0;
    case (state_q)
      IDLE:    wr_ready = rstDone_q & slotInRange & ~targetFull;
      LOAD:    wr_ready = 1'b1;
      COMMIT:  wr_ready = 1'b0;
      default: wr_ready = 1'b0;
    endcase
    for (int l = 0; l < N; l++) begin
      weA[l] = accept && (beatSel == MAT_A) && (beatRow == IW'(l));
      weB[l] = accept && (beatSel == MAT_B) && (beatCol == IW'(l));
    end
  end

  // A elements land in column word c (lane r); B elements in row word r
  // (lane c). Both share the same slot base.
  always_comb begin
    slotBase = AW'(beatSlot) * AW'(N);
    waddrA   = slotBase + AW'(beatCol);
    waddrB   = slotBase + AW'(beatRow);
  end

  // Beat position tracking. Row/column are kept alongside the linear count
  // so no divider is needed to locate an element. Any end of stream, good
  // or bad, rewinds everything to element 0.
  always_comb begin
    count_d = count_q;
    row_d   = row_q;
    col_d   = col_q;
    sel_d   = sel_q;
    slot_d  = slot_q;
    if (state_q == COMMIT) begin
      count_d = '0;
      row_d   = '0;
      col_d   = '0;
    end else if (accept) begin
      if (state_q == IDLE) begin
        sel_d  = beatSel;
        slot_d = beatSlot;
      end
      if (goodLast || frameErr) begin
        count_d = '0;
        row_d   = '0;
        col_d   = '0;
      end else begin
        count_d = beatIdx + CW'(1);
        if (beatCol == IW'(N - 1)) begin
          col_d = '0;
          row_d = beatRow + IW'(1);
        end else begin
          col_d = beatCol + IW'(1);
          row_d = beatRow;
        end
      end
    end
  end

  // Full flags. The release is applied first and the commit second, so a
  // release and commit hitting the same slot together leave the committed
  // flag set while the other matrix's flag is cleared.
  always_comb begin
    aFull_d = aFull_q;
    bFull_d = bFull_q;
    if (rel_valid && relInRange) begin
      aFull_d[rel_slot] = 1'b0;
      bFull_d[rel_slot] = 1'b0;
    end
    if (state_q == COMMIT) begin
      if (sel_q == MAT_A) begin
        aFull_d[slot_q] = 1'b1;
      end else begin
        bFull_d[slot_q] = 1'b1;
      end
    end
  end

  // Sticky error: a new framing error wins over a simultaneous clear.
  always_comb begin
    err_d = err_clr ? 1'b0 : err_q;
    if (frameErr) begin
      err_d = 1'b1;
    end
  end

  // Datapath, flag and error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      row_q     <= '0;
      col_q     <= '0;
      sel_q     <= MAT_A;
      slot_q    <= '0;
      aFull_q   <= '0;
      bFull_q   <= '0;
      err_q     <= 1'b0;
      rstDone_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      row_q     <= row_d;
      col_q     <= col_d;
      sel_q     <= sel_d;
      slot_q    <= slot_d;
      aFull_q   <= aFull_d;
      bFull_q   <= bFull_d;
      err_q     <= err_d;
      rstDone_q <= 1'b1;
    end
  end

  assign slot_ready = aFull_q & bFull_q;
  assign err        = err_q;

  operand_bank #(
    .LANES      (N),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) bankA (
    .clk     (clk),
    .rst     (rst),
    .we_i    (weA),
    .waddr_i (waddrA),
    .wdata_i (wr_data),
    .raddr_i (addr_matrix_A),
    .rdata_o (MATRIX_A_COL)
  );

  operand_bank #(
    .LANES      (N),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) bankB (
    .clk     (clk),
    .rst     (rst),
    .we_i    (weB),
    .waddr_i (waddrB),
    .wdata_i (wr_data),
    .raddr_i (addr_matrix_B),
    .rdata_o (MATRIX_B_ROW)
  );

endmodule

// File: tb/tb_matrix_operand_store.sv
// ---------------------------------------------------------------------------
// tb_matrix_operand_store
//
// Directed bench for matrix_operand_store with N=3, DW=8, two slots.
// Read-back of the loaded operands is checked from a table of hand-computed
// packed words; handshake, framing-error, release and reset corners are
// driven as short hand-written sequences.
// ---------------------------------------------------------------------------
module tb_matrix_operand_store;

  localparam int DW   = 8;
  localparam int LW   = 24;
  localparam int AW   = 3;
  localparam int SW   = 1;
  localparam int MAXM = 2;

  typedef struct {
    logic [AW-1:0] addrA;
    logic [AW-1:0] addrB;
    logic [LW-1:0] expA;
    logic [LW-1:0] expB;
  } readVec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_valid;
  logic            wr_ready;
  logic [DW-1:0]   wr_data;
  logic            wr_sel;
  logic [SW-1:0]   wr_slot;
  logic            wr_last;
  logic            rel_valid;
  logic [SW-1:0]   rel_slot;
  logic [AW-1:0]   addr_matrix_A;
  logic [AW-1:0]   addr_matrix_B;
  logic [LW-1:0]   MATRIX_A_COL;
  logic [LW-1:0]   MATRIX_B_ROW;
  logic [MAXM-1:0] slot_ready;
  logic            err;
  logic            err_clr;

  int checkCount = 0;
  int errorCount = 0;

  readVec_t vecs [8];

  always #5 clk = ~clk;

  matrix_operand_store #(
    .ARRAY_SIZE   (3),
    .DATA_WIDTH   (DW),
    .MAX_MATRICES (MAXM)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_data       (wr_data),
    .wr_sel        (wr_sel),
    .wr_slot       (wr_slot),
    .wr_last       (wr_last),
    .rel_valid     (rel_valid),
    .rel_slot      (rel_slot),
    .addr_matrix_A (addr_matrix_A),
    .addr_matrix_B (addr_matrix_B),
    .MATRIX_A_COL  (MATRIX_A_COL),
    .MATRIX_B_ROW  (MATRIX_B_ROW),
    .slot_ready    (slot_ready),
    .err           (err),
    .err_clr       (err_clr)
  );

  // Compare one observed value with its expected value and tally the result.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Put one table entry's read addresses on the bus and let reads settle.
  task automatic applyStimulus(input readVec_t v);
    addr_matrix_A = v.addrA;
    addr_matrix_B = v.addrB;
    #1;
  endtask

  // Present one element and hold it until accepted (bounded wait). Returns
  // 1 time unit after the accepting edge with wr_valid dropped.
  task automatic sendBeat(input logic [DW-1:0] d, input logic sel,
                          input logic [SW-1:0] slot, input logic last);
    int waitCycles;
    waitCycles = 0;
    wr_valid   = 1'b1;
    wr_data    = d;
    wr_sel     = sel;
    wr_slot    = slot;
    wr_last    = last;
    @(negedge clk);
    while (!wr_ready && waitCycles < 40) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!wr_ready) begin
      checkOutput("beat_accept_timeout", 32'(wr_ready), 32'd1);
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  // Stream a full, well-framed 3x3 matrix with values base..base+8.
  task automatic loadMatrix(input logic sel, input logic [SW-1:0] slot,
                            input logic [DW-1:0] base);
    for (int i = 0; i < 9; i++) begin
      sendBeat(base + DW'(i), sel, slot, (i == 8));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // A = 1..9, B = 10..18 in slot 0; slot 1 and addresses 6,7 read zero.
    vecs[0] = '{3'd0, 3'd0, 24'h070401, 24'h0C0B0A};
    vecs[1] = '{3'd1, 3'd1, 24'h080502, 24'h0F0E0D};
    vecs[2] = '{3'd2, 3'd2, 24'h090603, 24'h121110};
    vecs[3] = '{3'd3, 3'd3, 24'h000000, 24'h000000};
    vecs[4] = '{3'd4, 3'd4, 24'h000000, 24'h000000};
    vecs[5] = '{3'd5, 3'd5, 24'h000000, 24'h000000};
    vecs[6] = '{3'd6, 3'd6, 24'h000000, 24'h000000};
    vecs[7] = '{3'd7, 3'd7, 24'h000000, 24'h000000};

    rst           = 1'b1;
    wr_valid      = 1'b0;
    wr_data       = '0;
    wr_sel        = 1'b0;
    wr_slot       = '0;
    wr_last       = 1'b0;
    rel_valid     = 1'b0;
    rel_slot      = '0;
    addr_matrix_A = '0;
    addr_matrix_B = '0;
    err_clr       = 1'b0;

    // Reset state
    #2;
    checkOutput("reset_wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_slot_ready", 32'(slot_ready), 32'd0);
    checkOutput("reset_read_a0", 32'(MATRIX_A_COL), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("ready_before_first_edge", 32'(wr_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("ready_after_reset", 32'(wr_ready), 32'd1);

    // Load A = 1..9 into slot 0
    loadMatrix(1'b0, 1'b0, 8'd1);
    checkOutput("commit_ready_low", 32'(wr_ready), 32'd0);
    @(posedge clk);
    #1;
    wr_sel  = 1'b0;
    wr_slot = 1'b0;
    #1;
    checkOutput("a_full_blocks_ready", 32'(wr_ready), 32'd0);
    checkOutput("slot_ready_a_only", 32'(slot_ready), 32'd0);
    wr_sel = 1'b1;
    #1;
    checkOutput("b_empty_ready", 32'(wr_ready), 32'd1);

    // Load B = 10..18 into slot 0
    loadMatrix(1'b1, 1'b0, 8'd10);
    checkOutput("slot_ready_during_commit", 32'(slot_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("slot_ready_after_commit", 32'(slot_ready), 32'd1);

    // Table of packed read words
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("read_a_addr%0d", i), 32'(MATRIX_A_COL), 32'(vecs[i].expA));
      checkOutput($sformatf("read_b_addr%0d", i), 32'(MATRIX_B_ROW), 32'(vecs[i].expB));
    end

    // Full slot stalls the host until released
    wr_sel   = 1'b0;
    wr_slot  = 1'b0;
    wr_data  = 8'd21;
    wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("stall_cycle%0d", i), 32'(wr_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    rel_valid = 1'b1;
    rel_slot  = 1'b0;
    @(posedge clk);
    #1;
    rel_valid = 1'b0;
    checkOutput("ready_after_release", 32'(wr_ready), 32'd1);
    checkOutput("slot_ready_after_release", 32'(slot_ready), 32'd0);
    loadMatrix(1'b0, 1'b0, 8'd21);
    @(posedge clk);
    #1;
    addr_matrix_A = 3'd0;
    addr_matrix_B = 3'd1;
    #1;
    checkOutput("reload_a_col0", 32'(MATRIX_A_COL), 32'h001B1815);
    checkOutput("release_keeps_b_data", 32'(MATRIX_B_ROW), 32'h000F0E0D);

    // wr_last on beat 5 into slot 1 A
    for (int i = 0; i < 5; i++) begin
      sendBeat(8'd31 + DW'(i), 1'b0, 1'b1, (i == 4));
    end
    checkOutput("err_early_last", 32'(err), 32'd1);
    addr_matrix_A = 3'd3;
    #1;
    checkOutput("partial_a_slot1_col0", 32'(MATRIX_A_COL), 32'h0000221F);
    checkOutput("early_last_no_commit", 32'(wr_ready), 32'd1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    checkOutput("err_cleared_1", 32'(err), 32'd0);

    // Nine beats with no wr_last
    for (int i = 0; i < 9; i++) begin
      sendBeat(8'd41 + DW'(i), 1'b0, 1'b1, 1'b0);
    end
    checkOutput("err_missing_last", 32'(err), 32'd1);
    checkOutput("missing_last_no_commit", 32'(wr_ready), 32'd1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    checkOutput("err_cleared_2", 32'(err), 32'd0);

    // Clear and new error in the same cycle: error wins
    err_clr = 1'b1;
    sendBeat(8'd60, 1'b0, 1'b1, 1'b1);
    err_clr = 1'b0;
    checkOutput("err_clear_collision", 32'(err), 32'd1);

    // Release of slot 1 coincident with slot 1 B commit
    loadMatrix(1'b0, 1'b1, 8'd51);
    @(posedge clk);
    #1;
    wr_sel  = 1'b0;
    wr_slot = 1'b1;
    #1;
    checkOutput("slot1_a_full", 32'(wr_ready), 32'd0);
    loadMatrix(1'b1, 1'b1, 8'd71);
    rel_valid = 1'b1;
    rel_slot  = 1'b1;
    @(posedge clk);
    #1;
    rel_valid = 1'b0;
    wr_sel    = 1'b0;
    wr_slot   = 1'b1;
    #1;
    checkOutput("rel_commit_a_cleared", 32'(wr_ready), 32'd1);
    wr_sel = 1'b1;
    #1;
    checkOutput("rel_commit_b_kept", 32'(wr_ready), 32'd0);
    checkOutput("rel_commit_slot_ready", 32'(slot_ready), 32'd0);
    addr_matrix_B = 3'd4;
    #1;
    checkOutput("slot1_b_row1", 32'(MATRIX_B_ROW), 32'h004C4B4A);

    // Reset in the middle of a load, after four beats
    for (int i = 0; i < 4; i++) begin
      sendBeat(8'd81 + DW'(i), 1'b0, 1'b1, 1'b0);
    end
    rst = 1'b1;
    #1;
    checkOutput("midload_reset_wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("midload_reset_err", 32'(err), 32'd0);
    checkOutput("midload_reset_slot_ready", 32'(slot_ready), 32'd0);
    for (int a = 0; a < 8; a++) begin
      addr_matrix_A = AW'(a);
      addr_matrix_B = AW'(a);
      #1;
      checkOutput($sformatf("reset_read_a%0d", a), 32'(MATRIX_A_COL), 32'd0);
      checkOutput($sformatf("reset_read_b%0d", a), 32'(MATRIX_B_ROW), 32'd0);
    end
    @(negedge clk);
    rst     = 1'b0;
    wr_sel  = 1'b0;
    wr_slot = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("flags_cleared_by_reset", 32'(wr_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
